// File: rtl/sum_accumulator_pkg.sv
// Shared types and constants for the sum accumulator slice.
// Contents:
//   SUM_W   - width of the adder sum word {s3,s2,s1,s0}
//   state_t - accumulator control states
package sum_accumulator_pkg;

   localparam int unsigned SUM_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : sum_accumulator_pkg

// File: rtl/sum_accumulator_if.sv
// Control, input-handshake and result-handshake bundle of the sum accumulator.
// Ports (master = producer/consumer side, slave = accumulator):
//   start, sum_in, in_valid, out_ready                         master -> slave
//   in_ready, acc_out, out_valid, overflow, sample_cnt, busy   slave -> master
interface sum_accumulator_if
   import sum_accumulator_pkg::*;
#(
   parameter int unsigned ACC_W = 6,
   parameter int unsigned CNT_W = 4
);

   logic             start;
   logic [SUM_W-1:0] sum_in;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;
   logic [CNT_W-1:0] sample_cnt;
   logic             busy;

   modport master (
      output start, sum_in, in_valid, out_ready,
      input  in_ready, acc_out, out_valid, overflow, sample_cnt, busy
   );

   modport slave (
      input  start, sum_in, in_valid, out_ready,
      output in_ready, acc_out, out_valid, overflow, sample_cnt, busy
   );

endinterface : sum_accumulator_if

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES adder sums per start pulse and offers the total
// on a valid/ready handshake, with a sticky carry-out flag.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - sum_accumulator_if slave: start, sum_in/in_valid/in_ready,
//            acc_out/out_valid/out_ready, overflow, sample_cnt, busy
// The interface instance must use CNT_W = $clog2(N_SAMPLES+1).
module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int unsigned ACC_W     = 6,
   parameter int unsigned N_SAMPLES = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   sum_accumulator_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);

   state_t         state;
   state_t         state_nxt;
   logic           xfer_c;
   logic           last_c;
   logic [ACC_W:0] sum_c;

   // Transfer decode and the ACC_W+1-bit add whose top bit is the carry-out
   always_comb begin
      xfer_c = (state == ACCUM) && bus.in_valid;
      last_c = xfer_c && (bus.sample_cnt == CNT_W'(N_SAMPLES - 1));
      sum_c  = {1'b0, bus.acc_out} + (ACC_W + 1)'(bus.sum_in);
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)     state_nxt = ACCUM;
         ACCUM:   if (last_c)        state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // State register; handshake flags are registered copies of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.in_ready  <= (state_nxt == ACCUM);
         bus.out_valid <= (state_nxt == DONE);
         bus.busy      <= (state_nxt != IDLE);
      end
   end

   // Datapath: results of the previous run persist until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.acc_out    <= '0;
         bus.overflow   <= 1'b0;
         bus.sample_cnt <= '0;
      end else if ((state == IDLE) && bus.start) begin
         bus.acc_out    <= '0;
         bus.overflow   <= 1'b0;
         bus.sample_cnt <= '0;
      end else if (xfer_c) begin
         bus.acc_out    <= sum_c[ACC_W-1:0];
         bus.overflow   <= bus.overflow | sum_c[ACC_W];
         bus.sample_cnt <= bus.sample_cnt + CNT_W'(1);
      end
   end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: a reference model computes each
// run's expected total, pushes it to a scoreboard queue when the final sum is
// driven, and the entry is popped and compared when out_valid is seen.
// A second instance covers N_SAMPLES=1 with ACC_W=4.
module tb_sum_accumulator;

   localparam int unsigned ACC_W  = 6;
   localparam int unsigned NS     = 8;
   localparam int unsigned CNT_W  = $clog2(NS + 1);
   localparam int unsigned ACC1_W = 4;
   localparam int unsigned CNT1_W = $clog2(1 + 1);

   typedef struct {
      int unsigned acc;
      int unsigned ovf;
      int unsigned cnt;
   } result_t;

   logic clk;
   logic rst_n;

   int unsigned errors = 0;
   int unsigned checks = 0;

   result_t     sb[$];
   int unsigned m_acc;
   int unsigned m_ovf;
   int unsigned m_cnt;

   sum_accumulator_if #(.ACC_W(ACC_W),  .CNT_W(CNT_W))  bus  ();
   sum_accumulator_if #(.ACC_W(ACC1_W), .CNT_W(CNT1_W)) bus1 ();

   sum_accumulator #(.ACC_W(ACC_W), .N_SAMPLES(NS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sum_accumulator #(.ACC_W(ACC1_W), .N_SAMPLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      m_acc = 0;
      m_ovf = 0;
      m_cnt = 0;
   endtask

   // Idle gaps with in_valid low, then one transfer of v
   task automatic feed(input int unsigned v, input int unsigned gaps);
      int unsigned raw;
      for (int g = 0; g < int'(gaps); g++) begin
         tick();
         chk("gap_cnt", bus.sample_cnt, m_cnt);
      end
      chk("in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.sum_in   = 4'(v);
      tick();
      bus.in_valid = 1'b0;
      raw   = m_acc + v;
      m_ovf = m_ovf | ((raw >= (1 << ACC_W)) ? 1 : 0);
      m_acc = raw % (1 << ACC_W);
      m_cnt = m_cnt + 1;
      if (m_cnt == NS) begin
         sb.push_back('{acc: m_acc, ovf: m_ovf, cnt: m_cnt});
         chk("out_valid_lat", bus.out_valid, 1);
         chk("in_ready_drop", bus.in_ready, 0);
      end
   endtask

   task automatic expect_result(input string tag);
      result_t r;
      for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
      if (!bus.out_valid) begin
         chk({tag, "_timeout"}, 0, 1);
      end else if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         r = sb.pop_front();
         chk({tag, "_acc"}, bus.acc_out, r.acc);
         chk({tag, "_ovf"}, bus.overflow, r.ovf);
         chk({tag, "_cnt"}, bus.sample_cnt, r.cnt);
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("rel_valid", bus.out_valid, 0);
      chk("rel_busy", bus.busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;  bus.sum_in = '0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
      bus1.start = 1'b0; bus1.sum_in = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
      m_acc = 0; m_ovf = 0; m_cnt = 0;
      tick();
      tick();
      chk("rst_acc", bus.acc_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a run discards it asynchronously
      pulse_start();
      for (int i = 0; i < 3; i++) feed(5, 0);
      chk("pre_rst_cnt", bus.sample_cnt, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_acc", bus.acc_out, 0);
      chk("arst_cnt", bus.sample_cnt, 0);
      chk("arst_ready", bus.in_ready, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_ovf", bus.overflow, 0);
      chk("arst_valid", bus.out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_ready", bus.in_ready, 0);

      // in_valid while IDLE is ignored
      bus.in_valid = 1'b1; bus.sum_in = 4'd9;
      tick(); tick();
      bus.in_valid = 1'b0;
      chk("idle_iv_acc", bus.acc_out, 0);
      chk("idle_iv_cnt", bus.sample_cnt, 0);
      chk("idle_iv_busy", bus.busy, 0);

      // Basic run: 8 x 7
      pulse_start();
      chk("start_busy", bus.busy, 1);
      for (int i = 0; i < int'(NS); i++) feed(7, 0);
      expect_result("basic");
      release_result();
      chk("basic_hold", bus.acc_out, 56);

      // Overflow run: 8 x 15, flag sticky until the next start
      pulse_start();
      for (int i = 0; i < int'(NS); i++) feed(15, 0);
      expect_result("ovf");
      release_result();
      chk("ovf_persist", bus.overflow, 1);
      pulse_start();
      chk("ovf_clear", bus.overflow, 0);
      chk("acc_clear", bus.acc_out, 0);

      // Gapped run with sums 1..8 and a start pulse ignored in ACCUM
      for (int i = 1; i <= int'(NS); i++) begin
         if (i == 4) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("accum_start_cnt", bus.sample_cnt, m_cnt);
            chk("accum_start_acc", bus.acc_out, m_acc);
         end
         feed(i, (i == 1) ? 0 : 2);
      end
      expect_result("gaps");

      // Back-pressure: result held stable while out_ready is low
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_acc", bus.acc_out, 36);
      end

      // start and in_valid in DONE are ignored
      bus.start = 1'b1; bus.in_valid = 1'b1; bus.sum_in = 4'd3;
      tick();
      bus.start = 1'b0; bus.in_valid = 1'b0;
      chk("done_ign_acc", bus.acc_out, 36);
      chk("done_ign_cnt", bus.sample_cnt, NS);
      chk("done_ign_valid", bus.out_valid, 1);

      // start together with out_ready returns to IDLE without a new run
      bus.start = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.start = 1'b0; bus.out_ready = 1'b0;
      chk("so_valid", bus.out_valid, 0);
      tick();
      chk("so_busy", bus.busy, 0);
      chk("so_acc", bus.acc_out, 36);
      chk("so_cnt", bus.sample_cnt, NS);

      // Single-sample instance: 15 fits in 4 bits without carry
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      chk("n1_ready", bus1.in_ready, 1);
      bus1.in_valid = 1'b1; bus1.sum_in = 4'd15;
      tick();
      bus1.in_valid = 1'b0;
      chk("n1_valid", bus1.out_valid, 1);
      chk("n1_acc", bus1.acc_out, 15);
      chk("n1_ovf", bus1.overflow, 0);
      chk("n1_cnt", bus1.sample_cnt, 1);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      chk("n1_rel", bus1.out_valid, 0);

      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sum_accumulator
